spi_master_param: RTL

//  Parametrised single-master SPI engine. Successor to the fixed 8-bit mode-3 master.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_gen.sv | 42 ++++
 rtl/spi_master_param.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_gen.sv
// SCL generator: divides spi_clk by CLK_DIV and toggles SCL on each tick while
// toggling is enabled. lead_stb/trail_stb mark the cycle whose edge toggles SCL
// away from / back to the idle level.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic toggle_i,
  input  logic idle_lvl_i,
  output logic tick_o,
  output logic lead_stb_o,
  output logic trail_stb_o,
  output logic scl_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             scl_q;

  assign tick_o      = en_i && (div_q == DIV_W'(CLK_DIV - 1));
  assign lead_stb_o  = tick_o && toggle_i && (scl_q == idle_lvl_i);
  assign trail_stb_o = tick_o && toggle_i && (scl_q != idle_lvl_i);
  assign scl_o       = scl_q;

  // Divider: free-runs only while enabled, restarts from zero on every tick.
  always_ff @(posedge clk_i) begin
    if (rst_i)               div_q <= '0;
    else if (!en_i || tick_o) div_q <= '0;
    else                      div_q <= div_q + 1'b1;
  end

  // SCL: toggles on ticks while shifting, otherwise parks at the idle level.
  always_ff @(posedge clk_i) begin
    if (rst_i)                     scl_q <= 1'b0;
    else if (toggle_i && tick_o)   scl_q <= ~scl_q;
    else if (!toggle_i)            scl_q <= idle_lvl_i;
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: DATA_W-bit words, NUM_CS active-low selects, all four
// CPOL/CPHA modes, SCL half-period of CLK_DIV spi_clk cycles.
// Optional macro SPI_LSB_FIRST_EN adds a lsb_first input selecting LSB-first order.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_CS  = 1,
  parameter  int CLK_DIV = 2,
  localparam int CS_W    = ($clog2(NUM_CS) > 0) ? $clog2(NUM_CS) : 1
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_scl,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] spi_cs
`ifdef SPI_LSB_FIRST_EN
  ,
  input  logic              lsb_first
`endif
);

  localparam int EC_W = $clog2(2 * DATA_W);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

  spi_state_t        state_q;
  spi_mode_t         mode_q;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
  logic [EC_W-1:0]   edge_q;
  logic              busy_q, done_q, mosi_q;
  logic [NUM_CS-1:0] cs_q;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_q;
`endif

  logic              accept, cs_ok, idle_lvl;
  logic              tick, lead_stb, trail_stb, sample, drive;
  logic [NUM_CS-1:0] cs_dec;
  logic [DATA_W-1:0] tx_lat, rx_fin;

  assign cs_ok  = (int'(cs_sel) < NUM_CS);
  assign accept = (state_q == IDLE) && !busy_q && start && cs_ok;

  // SCL idle level follows the new cpol from the accept edge so SCL settles in LEAD.
  assign idle_lvl = accept ? cpol : mode_q.cpol;

  // cpha selects which SCL edge samples and which one launches the next bit.
  assign sample = mode_q.cpha ? trail_stb : lead_stb;
  assign drive  = mode_q.cpha ? lead_stb  : trail_stb;

  // One-hot-low select decode of the requested slave.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
  end

  // Bit-order mapping: reversing on the way in and out keeps the shifters MSB-first.
  always_comb begin
    tx_lat = tx_data;
    rx_fin = rx_q;
`ifdef SPI_LSB_FIRST_EN
    if (lsb_first)
      for (int i = 0; i < DATA_W; i++) tx_lat[i] = tx_data[DATA_W-1-i];
    if (lsb_q)
      for (int i = 0; i < DATA_W; i++) rx_fin[i] = rx_q[DATA_W-1-i];
`endif
  end

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i       (spi_clk),
    .rst_i       (reset),
    .en_i        (state_q != IDLE),
    .toggle_i    (state_q == XFER),
    .idle_lvl_i  (idle_lvl),
    .tick_o      (tick),
    .lead_stb_o  (lead_stb),
    .trail_stb_o (trail_stb),
    .scl_o       (spi_scl)
  );

  // Transfer FSM with shifters and registered pin/handshake outputs.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= SPI_MODE0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mosi_q    <= 1'b1;
      cs_q      <= '1;
`ifdef SPI_LSB_FIRST_EN
      lsb_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mosi_q <= 1'b1;
          busy_q <= 1'b0;
          if (accept) begin
            state_q <= LEAD;
            busy_q  <= 1'b1;
            mode_q  <= '{cpol: cpol, cpha: cpha};
            cs_q    <= cs_dec;
            rx_q    <= '0;
            edge_q  <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q   <= lsb_first;
`endif
            // cpha=0 presents the first bit during CS setup; cpha=1 waits for the leading edge.
            if (cpha) begin
              tx_q <= tx_lat;
            end else begin
              mosi_q <= tx_lat[DATA_W-1];
              tx_q   <= {tx_lat[DATA_W-2:0], 1'b1};
            end
          end
        end
        LEAD: begin
          if (tick) state_q <= XFER;
        end
        XFER: begin
          if (sample) rx_q <= {rx_q[DATA_W-2:0], miso};
          if (drive) begin
            mosi_q <= tx_q[DATA_W-1];
            tx_q   <= {tx_q[DATA_W-2:0], 1'b1};
          end
          if (tick) begin
            if (edge_q == LAST_EDGE) begin
              edge_q  <= '0;
              state_q <= TRAIL;
            end else begin
              edge_q <= edge_q + 1'b1;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            state_q   <= IDLE;
            cs_q      <= '1;
            mosi_q    <= 1'b1;
            done_q    <= 1'b1;
            rx_data_q <= rx_fin;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign mosi    = mosi_q;
  assign spi_cs  = cs_q;

endmodule
